// File: rtl/id_stage.sv
// Instruction decode stage: combinational decode of the incoming word, operand
// forwarding from EX/MEM, load-use stall detection and a valid/ready ID/EX register.
module id_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [31:0]        inst_i,
  output logic               reg1_read_o,
  output logic               reg2_read_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]  reg1_data_i,
  input  logic [DATA_W-1:0]  reg2_data_i,
  input  logic               ex_wreg_i,
  input  logic               ex_is_load_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               mem_wreg_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  pc_o,
  output logic [7:0]         aluop_o,
  output logic [2:0]         alusel_o,
  output logic [DATA_W-1:0]  reg1_o,
  output logic [DATA_W-1:0]  reg2_o,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o,
  output logic               is_load_o,
  output logic               instvalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_SUBU = 8'h23;
  localparam logic [7:0] ALU_LW   = 8'hE3;

  localparam logic [2:0] SEL_NOP       = 3'd0;
  localparam logic [2:0] SEL_LOGIC     = 3'd1;
  localparam logic [2:0] SEL_ARITH     = 3'd4;
  localparam logic [2:0] SEL_LOADSTORE = 3'd7;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [RADDR_W-1:0] rsAddr;
  logic [RADDR_W-1:0] rtAddr;
  logic [RADDR_W-1:0] rdAddr;

  logic [7:0]         decAluop;
  logic [2:0]         decAlusel;
  logic               decWreg;
  logic [RADDR_W-1:0] decWd;
  logic               decIsLoad;
  logic               decValid;
  logic               rd1En;
  logic               rd2En;
  logic [DATA_W-1:0]  imm1;
  logic [DATA_W-1:0]  imm2;
  logic [DATA_W-1:0]  operand1;
  logic [DATA_W-1:0]  operand2;

  logic exHit1, exHit2, memHit1, memHit2;
  logic stall;
  logic load;

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  pc_q;
  logic [7:0]         aluop_q;
  logic [2:0]         alusel_q;
  logic [DATA_W-1:0]  reg1_q;
  logic [DATA_W-1:0]  reg2_q;
  logic [RADDR_W-1:0] wd_q;
  logic               wreg_q;
  logic               is_load_q;
  logic               instvalid_q;

  assign opcode = inst_i[31:26];
  assign funct  = inst_i[5:0];
  assign shamt  = inst_i[10:6];
  assign imm    = inst_i[15:0];
  assign rsAddr = RADDR_W'(inst_i[25:21]);
  assign rtAddr = RADDR_W'(inst_i[20:16]);
  assign rdAddr = RADDR_W'(inst_i[15:11]);

  assign reg1_read_o = rd1En;
  assign reg2_read_o = rd2En;
  assign reg1_addr_o = rsAddr;
  assign reg2_addr_o = rtAddr;

  // imm1/imm2 are the values a source takes when it is not read from the register file.
  always_comb begin
    decAluop  = ALU_NOP;
    decAlusel = SEL_NOP;
    decWreg   = 1'b0;
    decWd     = '0;
    decIsLoad = 1'b0;
    decValid  = 1'b0;
    rd1En     = 1'b0;
    rd2En     = 1'b0;
    imm1      = '0;
    imm2      = '0;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: begin
        rd1En     = 1'b1;
        imm2      = DATA_W'(imm);
        decWd     = rtAddr;
        decWreg   = 1'b1;
        decValid  = 1'b1;
        decAlusel = SEL_LOGIC;
        case (opcode)
          OP_ANDI: decAluop = ALU_AND;
          OP_XORI: decAluop = ALU_XOR;
          default: decAluop = ALU_OR;
        endcase
      end
      OP_LUI: begin
        imm1      = DATA_W'({imm, 16'h0000});
        decWd     = rtAddr;
        decWreg   = 1'b1;
        decValid  = 1'b1;
        decAluop  = ALU_OR;
        decAlusel = SEL_LOGIC;
      end
      OP_LW: begin
        rd1En     = 1'b1;
        imm2      = DATA_W'($signed(imm));
        decWd     = rtAddr;
        decWreg   = 1'b1;
        decIsLoad = 1'b1;
        decValid  = 1'b1;
        decAluop  = ALU_LW;
        decAlusel = SEL_LOADSTORE;
      end
      OP_SPECIAL: begin
        if (inst_i == 32'h0000_0000) begin
          decValid = 1'b1;
        end else if (shamt == 5'd0) begin
          decAlusel = SEL_LOGIC;
          case (funct)
            FN_AND:  decAluop = ALU_AND;
            FN_OR:   decAluop = ALU_OR;
            FN_XOR:  decAluop = ALU_XOR;
            FN_NOR:  decAluop = ALU_NOR;
            FN_ADDU: begin decAluop = ALU_ADDU; decAlusel = SEL_ARITH; end
            FN_SUBU: begin decAluop = ALU_SUBU; decAlusel = SEL_ARITH; end
            default: decAlusel = SEL_NOP;
          endcase
          if (decAluop != ALU_NOP) begin
            rd1En    = 1'b1;
            rd2En    = 1'b1;
            decWd    = rdAddr;
            decWreg  = 1'b1;
            decValid = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Register 0 reads as zero; EX is younger than MEM so it wins on a double match.
  always_comb begin
    operand1 = imm1;
    if (rd1En) begin
      if (rsAddr == '0)                                 operand1 = '0;
      else if (FWD_EN && ex_wreg_i && ex_wd_i == rsAddr)   operand1 = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && mem_wd_i == rsAddr) operand1 = mem_wdata_i;
      else                                              operand1 = reg1_data_i;
    end
  end

  always_comb begin
    operand2 = imm2;
    if (rd2En) begin
      if (rtAddr == '0)                                 operand2 = '0;
      else if (FWD_EN && ex_wreg_i && ex_wd_i == rtAddr)   operand2 = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && mem_wd_i == rtAddr) operand2 = mem_wdata_i;
      else                                              operand2 = reg2_data_i;
    end
  end

  assign exHit1  = rd1En && (rsAddr != '0) && ex_wreg_i  && (ex_wd_i  == rsAddr);
  assign exHit2  = rd2En && (rtAddr != '0) && ex_wreg_i  && (ex_wd_i  == rtAddr);
  assign memHit1 = rd1En && (rsAddr != '0) && mem_wreg_i && (mem_wd_i == rsAddr);
  assign memHit2 = rd2En && (rtAddr != '0) && mem_wreg_i && (mem_wd_i == rtAddr);

  // A load result is not available for forwarding yet; without forwarding any pending write blocks.
  assign stall = in_valid_i &&
                 ((ex_is_load_i && (exHit1 || exHit2)) ||
                  (!FWD_EN && (exHit1 || exHit2 || memHit1 || memHit2)));

  assign in_ready_o = flush_i || (!stall && (!valid_q || out_ready_i));

  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      load    = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Payload only changes on accept, so it stays stable while EX applies backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= '0;
      alusel_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      is_load_q   <= 1'b0;
      instvalid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        pc_q        <= pc_i;
        aluop_q     <= decAluop;
        alusel_q    <= decAlusel;
        reg1_q      <= operand1;
        reg2_q      <= operand2;
        wd_q        <= decWd;
        wreg_q      <= decWreg;
        is_load_q   <= decIsLoad;
        instvalid_q <= decValid;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign pc_o        = pc_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign is_load_o   = is_load_q;
  assign instvalid_o = instvalid_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic compared against
// an instruction-level reference model of decode, forwarding, stalls and handshake.
module tb_id_stage;

  localparam bit FWD = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, inValid, outReady;
  logic [31:0] pc, inst, rf1, rf2, exData, memData;
  logic        exWreg, exIsLoad, memWreg;
  logic [4:0]  exWd, memWd;

  logic        inReady, rd1, rd2, outValid, wreg, isLoad, instvalid;
  logic [4:0]  addr1, addr2, wd;
  logic [31:0] pcOut, op1Out, op2Out;
  logic [7:0]  aluop;
  logic [2:0]  alusel;

  int checks   = 0;
  int failures = 0;

  logic        eValid, eWreg, eIsLoad, eInstvalid;
  logic [31:0] ePc, eReg1, eReg2;
  logic [7:0]  eAluop;
  logic [2:0]  eAlusel;
  logic [4:0]  eWd;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        isLoad;
    logic        valid;
    logic        r1en;
    logic        r2en;
    logic [31:0] imm1;
    logic [31:0] imm2;
  } dec_t;

  id_stage #(.DATA_W(32), .RADDR_W(5), .FWD_EN(FWD)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady),
    .pc_i(pc), .inst_i(inst),
    .reg1_read_o(rd1), .reg2_read_o(rd2), .reg1_addr_o(addr1), .reg2_addr_o(addr2),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(exWreg), .ex_is_load_i(exIsLoad), .ex_wd_i(exWd), .ex_wdata_i(exData),
    .mem_wreg_i(memWreg), .mem_wd_i(memWd), .mem_wdata_i(memData),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .pc_o(pcOut), .aluop_o(aluop), .alusel_o(alusel), .reg1_o(op1Out), .reg2_o(op2Out),
    .wd_o(wd), .wreg_o(wreg), .is_load_o(isLoad), .instvalid_o(instvalid)
  );

  always #5 clk = ~clk;

  // Instruction semantics written straight from the opcode table.
  function automatic dec_t refDecode(input logic [31:0] w);
    dec_t d;
    logic [15:0] im;
    d  = '0;
    im = w[15:0];
    case (w[31:26])
      6'h0c, 6'h0d, 6'h0e: begin
        d.aluop  = (w[31:26] == 6'h0c) ? 8'h24 : (w[31:26] == 6'h0d) ? 8'h25 : 8'h26;
        d.alusel = 3'd1; d.r1en = 1'b1; d.imm2 = {16'h0, im};
        d.wd = w[20:16]; d.wreg = 1'b1; d.valid = 1'b1;
      end
      6'h0f: begin
        d.aluop = 8'h25; d.alusel = 3'd1; d.imm1 = {im, 16'h0};
        d.wd = w[20:16]; d.wreg = 1'b1; d.valid = 1'b1;
      end
      6'h23: begin
        d.aluop = 8'hE3; d.alusel = 3'd7; d.r1en = 1'b1; d.imm2 = {{16{im[15]}}, im};
        d.wd = w[20:16]; d.wreg = 1'b1; d.isLoad = 1'b1; d.valid = 1'b1;
      end
      6'h00: begin
        if (w == 32'h0) d.valid = 1'b1;
        else if (w[10:6] == 5'd0 && w[5:0] inside {6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23}) begin
          d.aluop  = {2'b00, w[5:0]};
          d.alusel = (w[5:0] == 6'h21 || w[5:0] == 6'h23) ? 3'd4 : 3'd1;
          d.r1en = 1'b1; d.r2en = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.valid = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] srcValue(input logic en, input logic [4:0] a,
                                           input logic [31:0] rf, input logic [31:0] immv);
    if (!en)                              return immv;
    if (a == 5'd0)                        return 32'h0;
    if (FWD && exWreg && exWd == a)       return exData;
    if (FWD && memWreg && memWd == a)     return memData;
    return rf;
  endfunction

  function automatic logic srcHazard(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 1'b0;
    if (exIsLoad && exWreg && exWd == a) return 1'b1;
    if (!FWD && ((exWreg && exWd == a) || (memWreg && memWd == a))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] randInst();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: fn = 6'h21;
      1: fn = 6'h23;
      2: fn = 6'h27;
      default: fn = 6'h24;
    endcase
    case ($urandom_range(0, 9))
      0: return {6'h0d, rs, rt, 16'($urandom)};
      1: return {6'h0c, rs, rt, 16'($urandom)};
      2: return {6'h0e, rs, rt, 16'($urandom)};
      3: return {6'h0f, rs, rt, 16'($urandom)};
      4: return {6'h23, rs, rt, 16'($urandom)};
      5, 6: return {6'h00, rs, rt, rd, 5'd0, fn};
      7: return 32'h0;
      8: return {6'h00, rs, rt, rd, 5'd3, fn};
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("out_valid", outValid, eValid);
    if (eValid) begin
      checkOutput("pc", pcOut, ePc);
      checkOutput("aluop", aluop, eAluop);
      checkOutput("alusel", alusel, eAlusel);
      checkOutput("reg1", op1Out, eReg1);
      checkOutput("reg2", op2Out, eReg2);
      checkOutput("wd", wd, eWd);
      checkOutput("wreg", wreg, eWreg);
      checkOutput("is_load", isLoad, eIsLoad);
      checkOutput("instvalid", instvalid, eInstvalid);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_wreg", wreg, 1'b0);
    checkOutput("rst_is_load", isLoad, 1'b0);
    checkOutput("rst_instvalid", instvalid, 1'b0);
    checkOutput("rst_pc", pcOut, 32'h0);
    checkOutput("rst_aluop", aluop, 8'h0);
    checkOutput("rst_alusel", alusel, 3'h0);
    checkOutput("rst_reg1", op1Out, 32'h0);
    checkOutput("rst_reg2", op2Out, 32'h0);
    checkOutput("rst_wd", wd, 5'h0);
  endtask

  // Inputs are already driven; check the combinational side, clock once, check the register.
  task automatic applyStimulus();
    dec_t d;
    logic stall, rdy;
    logic [31:0] v1, v2;
    #1;
    d = refDecode(inst);
    checkOutput("reg1_read", rd1, d.r1en);
    checkOutput("reg2_read", rd2, d.r2en);
    checkOutput("reg1_addr", addr1, inst[25:21]);
    checkOutput("reg2_addr", addr2, inst[20:16]);
    stall = inValid && (srcHazard(d.r1en, inst[25:21]) || srcHazard(d.r2en, inst[20:16]));
    rdy   = flush || (!stall && (!eValid || outReady));
    checkOutput("in_ready", inReady, rdy);
    v1 = srcValue(d.r1en, inst[25:21], rf1, d.imm1);
    v2 = srcValue(d.r2en, inst[20:16], rf2, d.imm2);
    @(posedge clk);
    #1;
    if (flush) eValid = 1'b0;
    else if (inValid && rdy) begin
      eValid = 1'b1; ePc = pc; eAluop = d.aluop; eAlusel = d.alusel; eReg1 = v1; eReg2 = v2;
      eWd = d.wd; eWreg = d.wreg; eIsLoad = d.isLoad; eInstvalid = d.valid;
    end else if (outReady) eValid = 1'b0;
    checkRegs();
  endtask

  task automatic quietSides();
    exWreg = 0; exIsLoad = 0; exWd = 0; exData = 0;
    memWreg = 0; memWd = 0; memData = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0; inValid = 0; outReady = 1; pc = 0; inst = 0; rf1 = 0; rf2 = 0;
    quietSides();
    eValid = 0; ePc = 0; eAluop = 0; eAlusel = 0; eReg1 = 0; eReg2 = 0;
    eWd = 0; eWreg = 0; eIsLoad = 0; eInstvalid = 0;
    #2;
    checkReset();
    @(posedge clk); #1;
    rst = 1'b1;

    // ORI r2 = r1 | 0x0F0F
    inValid = 1; pc = 32'h100; inst = 32'h3422_0F0F; rf1 = 32'hF0; rf2 = 32'hDEAD;
    applyStimulus();
    checkOutput("ori_aluop", aluop, 8'h25);
    checkOutput("ori_alusel", alusel, 3'd1);
    checkOutput("ori_reg1", op1Out, 32'hF0);
    checkOutput("ori_reg2", op2Out, 32'h0F0F);
    checkOutput("ori_wd", wd, 5'd2);

    // ADDU r3 = r1 + r2 with EX/MEM forwarding
    pc = 32'h104; inst = 32'h0022_1821; rf1 = 32'hFF; rf2 = 32'hFF;
    exWreg = 1; exWd = 1; exData = 32'h11; memWreg = 1; memWd = 2; memData = 32'h22;
    applyStimulus();
    checkOutput("fwd_reg1", op1Out, 32'h11);
    checkOutput("fwd_reg2", op2Out, 32'h22);
    pc = 32'h108; memWd = 1;
    applyStimulus();
    checkOutput("fwd_prio_reg1", op1Out, 32'h11);
    checkOutput("fwd_prio_reg2", op2Out, 32'hFF);

    // load-use: one bubble, then accepted
    quietSides();
    pc = 32'h10C; inst = 32'h3422_0F0F; exIsLoad = 1; exWreg = 1; exWd = 1; exData = 32'h55;
    applyStimulus();
    checkOutput("loaduse_bubble", outValid, 1'b0);
    exIsLoad = 0;
    applyStimulus();
    checkOutput("loaduse_accept", outValid, 1'b1);

    // backpressure for three cycles
    quietSides();
    outReady = 0; pc = 32'h200; inst = 32'h3422_1234;
    applyStimulus();
    pc = 32'h204; inst = 32'h3064_00FF;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("bp_held_aluop", aluop, 8'h25);
    outReady = 1;
    applyStimulus();
    checkOutput("bp_new_aluop", aluop, 8'h24);

    // flush of a held LW, then an undecodable word
    inValid = 0;
    applyStimulus();
    inValid = 1; outReady = 0; pc = 32'h300; inst = 32'h8C22_FFFC; rf1 = 32'h1000;
    applyStimulus();
    checkOutput("lw_reg2", op2Out, 32'hFFFF_FFFC);
    flush = 1; inst = 32'h3422_0001;
    applyStimulus();
    checkOutput("flush_valid", outValid, 1'b0);
    flush = 0; outReady = 1; pc = 32'h304; inst = 32'hFC00_0000;
    applyStimulus();
    checkOutput("bad_instvalid", instvalid, 1'b0);
    checkOutput("bad_wreg", wreg, 1'b0);

    $display("[TB] random phase");
    for (int n = 0; n < 400; n++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      pc = $urandom; inst = randInst(); rf1 = $urandom; rf2 = $urandom;
      exWreg = $urandom_range(0, 1); exIsLoad = $urandom_range(0, 1);
      exWd = 5'($urandom_range(0, 3)); exData = $urandom;
      memWreg = $urandom_range(0, 1); memWd = 5'($urandom_range(0, 3)); memData = $urandom;
      applyStimulus();
    end

    // asynchronous reset in the middle of traffic
    quietSides();
    inValid = 1; outReady = 1; pc = 32'h400; inst = 32'h8C22_0004;
    applyStimulus();
    #2;
    rst = 1'b0;
    #1;
    checkReset();
    eValid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    pc = 32'h500; inst = 32'h3C05_ABCD;
    applyStimulus();
    checkOutput("lui_reg1", op1Out, 32'hABCD_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
